// File: rtl/mem_responder_if.sv
// Valid/ready memory bus between a core port (master) and a memory responder (slave).
interface mem_responder_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_responder.sv
// Word-organised memory responder: one request at a time, LATENCY wait states,
// single-cycle ready pulse; byte-strobe writes, fetches never write.
module mem_responder #(
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 1,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input logic            clk,
    input logic            rst,
    mem_responder_if.slave bus
);
    localparam int WORDS = 1 << DEPTH_LOG2;

    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
        $error("mem_responder: LATENCY must be in 0..15");
    end

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        req_instr;
    logic [31:0] rdata_q;
    logic        ready_q;

    logic [31:0] store [0:WORDS-1];

    logic [31:0]           off;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  in_range;
    logic                  is_write;

    // Shifts instead of part-selects keep the decode legal for any DEPTH_LOG2.
    always_comb begin
        off      = req_addr - BASE_ADDR;
        idx      = DEPTH_LOG2'(off >> 2);
        in_range = (off >> (DEPTH_LOG2 + 2)) == '0;
        is_write = (req_wstrb != '0) && !req_instr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_wstrb <= '0;
            req_instr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mem_valid) begin
                        req_addr  <= bus.mem_addr;
                        req_wdata <= bus.mem_wdata;
                        req_wstrb <= bus.mem_wstrb;
                        req_instr <= bus.mem_instr;
                        cnt       <= 4'(LATENCY);
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state   <= RESP;
                        ready_q <= 1'b1;
                        rdata_q <= (!is_write && in_range) ? store[idx] : '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                    rdata_q <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The write commits on the edge that leaves RESP, so a reset there still aborts it.
    always_ff @(posedge clk) begin
        if (!rst && state == RESP && is_write && in_range) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (req_wstrb[k]) store[idx][8*k +: 8] <= req_wdata[8*k +: 8];
            end
        end
    end

    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: four instances (latency 1/0/5/3), scoreboard of
// expected read data popped on every ready pulse.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          sel;

    always #5 clk = ~clk;

    mem_responder_if bus0 ();
    mem_responder_if bus1 ();
    mem_responder_if bus2 ();
    mem_responder_if bus3 ();

    assign bus0.mem_valid = valid && (sel == 0);
    assign bus1.mem_valid = valid && (sel == 1);
    assign bus2.mem_valid = valid && (sel == 2);
    assign bus3.mem_valid = valid && (sel == 3);
    assign bus0.mem_instr = instr;
    assign bus1.mem_instr = instr;
    assign bus2.mem_instr = instr;
    assign bus3.mem_instr = instr;
    assign bus0.mem_addr  = addr;
    assign bus1.mem_addr  = addr;
    assign bus2.mem_addr  = addr;
    assign bus3.mem_addr  = addr;
    assign bus0.mem_wdata = wdata;
    assign bus1.mem_wdata = wdata;
    assign bus2.mem_wdata = wdata;
    assign bus3.mem_wdata = wdata;
    assign bus0.mem_wstrb = wstrb;
    assign bus1.mem_wstrb = wstrb;
    assign bus2.mem_wstrb = wstrb;
    assign bus3.mem_wstrb = wstrb;

    mem_responder #(.DEPTH_LOG2(12), .LATENCY(1), .BASE_ADDR(32'h0000_0000))
        u_l1 (.clk(clk), .rst(rst), .bus(bus0.slave));
    mem_responder #(.DEPTH_LOG2(12), .LATENCY(0), .BASE_ADDR(32'h0000_0000))
        u_l0 (.clk(clk), .rst(rst), .bus(bus1.slave));
    mem_responder #(.DEPTH_LOG2(12), .LATENCY(5), .BASE_ADDR(32'h8000_0000))
        u_l5 (.clk(clk), .rst(rst), .bus(bus2.slave));
    mem_responder #(.DEPTH_LOG2(12), .LATENCY(3), .BASE_ADDR(32'h0000_0000))
        u_l3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    logic        obs_ready;
    logic [31:0] obs_rdata;

    always_comb begin
        obs_ready = bus0.mem_ready;
        obs_rdata = bus0.mem_rdata;
        case (sel)
            1: begin obs_ready = bus1.mem_ready; obs_rdata = bus1.mem_rdata; end
            2: begin obs_ready = bus2.mem_ready; obs_rdata = bus2.mem_rdata; end
            3: begin obs_ready = bus3.mem_ready; obs_rdata = bus3.mem_rdata; end
            default: ;
        endcase
    end

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q [$];
    logic        mon_en = 1'b0;
    logic [31:0] mon_exp;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Every ready pulse must match the oldest outstanding expectation; rdata is 0 otherwise.
    always @(negedge clk) begin
        if (mon_en) begin
            if (obs_ready === 1'b1) begin
                chk("unexpected_ready", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    mon_exp = exp_q.pop_front();
                    chk("resp_rdata", obs_rdata, mon_exp);
                end
            end else begin
                chk("idle_rdata_zero", obs_rdata, 32'h0);
            end
        end
    end

    task automatic do_req(input int s, input logic ins, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] st, input logic [31:0] exp_rd, input int lat,
                          input logic hold, input string tag);
        int  k;
        logic got;
        @(negedge clk);
        sel = s; instr = ins; addr = a; wdata = d; wstrb = st; valid = 1'b1;
        exp_q.push_back(exp_rd);
        @(posedge clk);
        #1;
        addr  = $urandom;
        wdata = $urandom;
        wstrb = 4'($urandom);
        if (!hold) valid = 1'b0;
        k = 0;
        got = 1'b0;
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            if (obs_ready === 1'b1) got = 1'b1;
        end
        valid = 1'b0;
        chk({tag, "_latency"}, got ? 32'(k) : 32'hFFFF_FFFF, 32'(lat + 2));
        @(negedge clk);
        chk({tag, "_pulse_width"}, 32'(obs_ready), 32'd0);
    endtask

    task automatic sweep(input int s, input logic [31:0] a, input logic [31:0] exp_rd,
                         input int lat, input string tag);
        int n;
        int k;
        int last;
        @(negedge clk);
        sel = s; instr = 1'b0; addr = a; wdata = '0; wstrb = '0; valid = 1'b1;
        repeat (4) exp_q.push_back(exp_rd);
        n = 0; k = 0; last = 0;
        while (n < 4 && k < 100) begin
            @(negedge clk);
            k++;
            if (obs_ready === 1'b1) begin
                chk({tag, "_spacing"}, 32'(k - last), (n == 0) ? 32'(lat + 2) : 32'(lat + 3));
                last = k;
                n++;
            end
        end
        valid = 1'b0;
        chk({tag, "_pulses"}, 32'(n), 32'd4);
        @(negedge clk);
        chk({tag, "_pulse_width"}, 32'(obs_ready), 32'd0);
    endtask

    initial begin
        valid = 1'b0; instr = 1'b0; addr = '0; wdata = '0; wstrb = '0; sel = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready_l1", 32'(bus0.mem_ready), 32'd0);
        chk("reset_rdata_l1", bus0.mem_rdata, 32'h0);
        chk("reset_ready_l0", 32'(bus1.mem_ready), 32'd0);
        chk("reset_rdata_l0", bus1.mem_rdata, 32'h0);
        chk("reset_ready_l5", 32'(bus2.mem_ready), 32'd0);
        chk("reset_rdata_l5", bus2.mem_rdata, 32'h0);
        chk("reset_ready_l3", 32'(bus3.mem_ready), 32'd0);
        chk("reset_rdata_l3", bus3.mem_rdata, 32'h0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Latency 1, base 0: full write, byte strobes, address low bits ignored.
        do_req(0, 1'b0, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0,         1, 1'b1, "wr_full");
        do_req(0, 1'b0, 32'h10, 32'h0,         4'h0, 32'hDEAD_BEEF, 1, 1'b1, "rd_full");
        do_req(0, 1'b0, 32'h10, 32'h0000_00AA, 4'h1, 32'h0,         1, 1'b1, "wr_b0");
        do_req(0, 1'b0, 32'h10, 32'h0,         4'h0, 32'hDEAD_BEAA, 1, 1'b1, "rd_b0");
        do_req(0, 1'b0, 32'h10, 32'h1122_3344, 4'hC, 32'h0,         1, 1'b1, "wr_hi");
        do_req(0, 1'b0, 32'h10, 32'h0,         4'h0, 32'h1122_BEAA, 1, 1'b1, "rd_hi");
        do_req(0, 1'b0, 32'h13, 32'h0,         4'h0, 32'h1122_BEAA, 1, 1'b1, "rd_unaligned");

        // Out of range: no data, no aliasing onto word 0.
        do_req(0, 1'b0, 32'h0,    32'h1357_9BDF, 4'hF, 32'h0,         1, 1'b1, "wr_w0");
        do_req(0, 1'b0, 32'h4000, 32'h0,         4'h0, 32'h0,         1, 1'b1, "rd_oor");
        do_req(0, 1'b0, 32'h4000, 32'hFFFF_FFFF, 4'hF, 32'h0,         1, 1'b1, "wr_oor");
        do_req(0, 1'b0, 32'h0,    32'h0,         4'h0, 32'h1357_9BDF, 1, 1'b1, "rd_w0");

        // Fetch with strobes set must behave as a read.
        do_req(0, 1'b0, 32'h20, 32'hCAFE_F00D, 4'hF, 32'h0,         1, 1'b1, "wr_fetchsrc");
        do_req(0, 1'b1, 32'h20, 32'h1234_5678, 4'hF, 32'hCAFE_F00D, 1, 1'b1, "fetch_wstrb");
        do_req(0, 1'b0, 32'h20, 32'h0,         4'h0, 32'hCAFE_F00D, 1, 1'b1, "rd_after_fetch");

        // Latency 0 sweep with valid held.
        do_req(1, 1'b0, 32'h0, 32'hA5A5_0001, 4'hF, 32'h0, 0, 1'b1, "l0_wr");
        sweep(1, 32'h0, 32'hA5A5_0001, 0, "l0_sweep");

        // Latency 5, base 0x8000_0000: sweep plus decode below/far from base.
        do_req(2, 1'b0, 32'h8000_0004, 32'h0BAD_CAFE, 4'hF, 32'h0, 5, 1'b1, "l5_wr");
        sweep(2, 32'h8000_0004, 32'h0BAD_CAFE, 5, "l5_sweep");
        do_req(2, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 32'h0, 5, 1'b1, "l5_below_base");
        do_req(2, 1'b0, 32'h0000_0004, 32'h0, 4'h0, 32'h0, 5, 1'b1, "l5_far");

        // Latency 3: valid dropped during BUSY still completes.
        do_req(3, 1'b0, 32'h80, 32'h55AA_55AA, 4'hF, 32'h0,         3, 1'b0, "l3_wr_drop");
        do_req(3, 1'b0, 32'h80, 32'h0,         4'h0, 32'h55AA_55AA, 3, 1'b1, "l3_rd");

        // Reset in BUSY aborts the write and its ready pulse.
        @(negedge clk);
        sel = 3; instr = 1'b0; addr = 32'h80; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_ready", 32'(bus3.mem_ready), 32'd0);
        chk("rst_mid_rdata", bus3.mem_rdata, 32'h0);
        repeat (8) @(negedge clk);
        do_req(3, 1'b0, 32'h80, 32'h0, 4'h0, 32'h55AA_55AA, 3, 1'b1, "rst_store_kept");

        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the core's valid/ready memory interface: one instance serves the instruction port, another serves the data port.
- Holds a word-organised backing store that supports byte-strobe writes.
- Accepts one request at a time, inserts a configurable number of wait states, then answers with a single-cycle ready pulse.
- Used as the standalone simulation memory behind the cpu top and as the on-chip RAM in small SoC builds.

Parameters:
DEPTH_LOG2  12  log2 of store size in 32-bit words (default 16 KiB)
LATENCY  1  wait cycles between request capture and ready pulse (0..15)
BASE_ADDR  32'h0  byte address of word 0; must be aligned to 4*2^DEPTH_LOG2

Ports:
clk  in  1  clock
rst  in  1  reset
mem_valid  in  1  request present; held by initiator until ready
mem_instr  in  1  request is an instruction fetch
mem_addr  in  32  byte address; bits [1:0] ignored
mem_wdata  in  32  write data
mem_wstrb  in  4  byte write enables; 4'b0000 = read
mem_rdata  out  32  read data, valid only while mem_ready=1
mem_ready  out  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: mem_ready=0, mem_rdata=0, state=IDLE, wait counter=0.
- Reset does not clear the store. Reset during BUSY or RESP aborts the transaction: no write occurs and no ready pulse follows.
- State machine has three states: IDLE, BUSY, RESP.
- IDLE:
  - If mem_valid=1 at a rising edge, capture addr, wdata, wstrb and instr into request registers.
  - Load counter with LATENCY and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - If counter=0, go to RESP. Otherwise decrement the counter.
  - With LATENCY=0, BUSY lasts exactly one cycle.
- RESP:
  - mem_ready=1 for exactly this cycle, then return to IDLE.
  - Timing: if valid is first seen at edge N, ready is high in cycle N+LATENCY+2.
- Back-to-back requests: IDLE samples mem_valid in the cycle after RESP. Minimum request-to-request spacing is LATENCY+3 cycles.
- The responder never accepts a request in the RESP cycle, even if valid is still high.
- Address decode:
  - off = mem_addr - BASE_ADDR, computed in 32-bit modular arithmetic.
  - index = off[DEPTH_LOG2+1:2].
  - In range when off[31:DEPTH_LOG2+2] == 0.
- Reads (captured wstrb=0):
  - In range: mem_rdata = store[index] during RESP.
  - Out of range: mem_rdata = 0 during RESP.
- Writes (captured wstrb≠0):
  - In range: at the RESP edge, byte lane k of store[index] is updated from wdata[8k+7:8k] for each k with wstrb[k]=1. Unselected bytes are unchanged.
  - Out of range: write is dropped.
  - mem_rdata = 0 during a write's RESP cycle.
- Fetch writes: captured instr=1 with wstrb≠0 is treated as a read. Nothing is written; rdata returns store contents.
- Ready pulse is always produced, including for out-of-range accesses.
- mem_rdata = 0 in every cycle where mem_ready=0.
- Request fields are captured, so initiator changes to addr/wdata/wstrb during BUSY are ignored.
- If valid drops during BUSY (protocol violation), the captured transaction still completes with a ready pulse.
- Counter is 4 bits wide. LATENCY>15 is illegal; elaboration fails via assertion.

Test Plan:
- LATENCY=1, BASE=0:
  - Write addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF, valid high at edge 0 → ready high only in cycle 3, rdata=0.
  - Then read 0x10 → rdata 0xDEADBEEF with the ready pulse.
- Byte strobes: after the full write above, write wdata 0x000000AA, wstrb 4'b0001 to 0x10, then read 0x10 → 0xDEADBEAA. Then write 0x11223344 with wstrb 4'b1100, read → 0x1122BEAA.
- Out of range with DEPTH_LOG2=12:
  - Read addr 0x4000 → ready pulse, rdata 0.
  - Write 0xFFFFFFFF to 0x4000, then read 0x0000 → previous contents unchanged (no aliasing).
- Fetch protection: instr=1, wstrb 4'hF, wdata 0x12345678 at 0x20 holding 0xCAFEF00D → rdata 0xCAFEF00D; a subsequent read still returns 0xCAFEF00D.
- Timing sweep: LATENCY=0 and LATENCY=5, with valid held high continuously → ready pulses every 3 and 8 cycles respectively, each exactly one cycle wide.
- Reset mid-operation: issue a write in LATENCY=3, assert rst in BUSY → no ready pulse, mem_ready=0 and mem_rdata=0 the cycle after rst; a subsequent read shows the store unmodified.
